// File: rtl/multi_zone_irrigation_scheduler_if.sv
// multi_zone_irrigation_scheduler_if: sensor inputs and actuator outputs of the irrigation scheduler
interface multi_zone_irrigation_scheduler_if #(
  parameter int ZONES       = 4,
  parameter int TIMER_WIDTH = 8
) ();
  localparam int ZW = $clog2(ZONES);
  logic                   low_water_level;
  logic                   mid_water_level;
  logic                   high_water_level;
  logic                   air_humidity;
  logic                   low_temperature;
  logic [ZONES-1:0]       earth_humidity;
  logic                   abort;
  logic [ZONES-1:0]       zone_valve;
  logic [ZW-1:0]          active_zone;
  logic                   splinker_bomb;
  logic                   dripper_valvule;
  logic [TIMER_WIDTH-1:0] remaining_seconds;
  logic                   water_supply_valvule;
  logic                   alarm;
  logic                   conflicting_values;
  modport slave (
    input  low_water_level, mid_water_level, high_water_level, air_humidity, low_temperature,
           earth_humidity, abort,
    output zone_valve, active_zone, splinker_bomb, dripper_valvule, remaining_seconds,
           water_supply_valvule, alarm, conflicting_values
  );
  modport master (
    output low_water_level, mid_water_level, high_water_level, air_humidity, low_temperature,
           earth_humidity, abort,
    input  zone_valve, active_zone, splinker_bomb, dripper_valvule, remaining_seconds,
           water_supply_valvule, alarm, conflicting_values
  );
endinterface

// File: rtl/multi_zone_irrigation_scheduler.sv
// multi_zone_irrigation_scheduler: round-robin multi-zone irrigation FSM with per-run timer, supply hysteresis and conflict alarm
module multi_zone_irrigation_scheduler #(
  parameter int ZONES          = 4,
  parameter int TIMER_WIDTH    = 8,
  parameter int TICK_DIV       = 50_000_000,
  parameter int SPRINKLER_TIME = 60,
  parameter int DRIPPER_TIME   = 180
) (
  input logic clock,
  input logic reset,
  multi_zone_irrigation_scheduler_if.slave bus
);
  localparam int ZW = $clog2(ZONES);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [ZONES-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, ERROR} state_t;
  state_t state_q, state_d;
  logic [ZW-1:0] ptr_q, ptr_d, zone_q, zone_d, cand, nxt;
  logic [ZW:0] sum;
  logic [TIMER_WIDTH-1:0] rem_q, rem_d;
  logic [PW-1:0] pre_q, pre_d;
  logic mode_q, mode_d, supply_q, supply_d, conf_q, alarm_q;
  logic conflict_now, tick, spr, low, mid, high;
  logic [ZONES-1:0] req;
  assign low          = bus.low_water_level;
  assign mid          = bus.mid_water_level;
  assign high         = bus.high_water_level;
  assign conflict_now = (mid & ~low) | (high & ~mid);
  assign req          = ~bus.earth_humidity;
  assign tick         = pre_q == PW'(TICK_DIV - 1);
  assign spr          = mid & ~bus.air_humidity & ~bus.low_temperature;
  assign nxt          = zone_q == ZW'(ZONES - 1) ? '0 : zone_q + 1'b1;
  assign supply_d     = conflict_now ? 1'b0 : ~mid ? 1'b1 : high ? 1'b0 : supply_q;
  always_comb begin
    cand = '0;
    sum  = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (ZW + 1)'(i);
      sum = sum >= (ZW + 1)'(ZONES) ? sum - (ZW + 1)'(ZONES) : sum;
      cand = req[sum[ZW-1:0]] ? sum[ZW-1:0] : cand;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    zone_d  = zone_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE: begin
        if (conflict_now) state_d = ERROR;
        else if (low && |req) begin
          state_d = RUN;
          zone_d  = cand;
          mode_d  = spr;
          rem_d   = spr ? TIMER_WIDTH'(SPRINKLER_TIME) : TIMER_WIDTH'(DRIPPER_TIME);
          pre_d   = '0;
        end
      end
      RUN: begin
        if (conflict_now) begin
          state_d = ERROR;
          rem_d   = '0;
        end else if (bus.abort || bus.earth_humidity[zone_q]) begin
          state_d = IDLE;
          ptr_d   = nxt;
          rem_d   = '0;
        end else if (!low) state_d = HOLD;
        else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          rem_d = tick ? rem_q - 1'b1 : rem_q;
          state_d = tick && rem_q == 1 ? IDLE : RUN;
          ptr_d = tick && rem_q == 1 ? nxt : ptr_q;
        end
      end
      HOLD: begin
        if (conflict_now) begin
          state_d = ERROR;
          rem_d   = '0;
        end else if (bus.abort) begin
          state_d = IDLE;
          ptr_d   = nxt;
          rem_d   = '0;
        end else if (low) state_d = RUN;
      end
      default: state_d = conflict_now ? ERROR : IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      zone_q   <= '0;
      mode_q   <= 1'b0;
      rem_q    <= '0;
      pre_q    <= '0;
      supply_q <= 1'b0;
      conf_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      zone_q   <= zone_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      pre_q    <= pre_d;
      supply_q <= supply_d;
      conf_q   <= conflict_now;
      alarm_q  <= conflict_now | ~mid;
    end
  end
  assign bus.zone_valve           = state_q == RUN ? ONE << zone_q : '0;
  assign bus.active_zone          = zone_q;
  assign bus.splinker_bomb        = state_q == RUN && mode_q;
  assign bus.dripper_valvule      = state_q == RUN && !mode_q;
  assign bus.remaining_seconds    = rem_q;
  assign bus.water_supply_valvule = supply_q;
  assign bus.alarm                = alarm_q;
  assign bus.conflicting_values   = conf_q;
endmodule

// File: tb/tb_multi_zone_irrigation_scheduler.sv
// tb_multi_zone_irrigation_scheduler: directed self-checking bench for the irrigation scheduler
module tb_multi_zone_irrigation_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  multi_zone_irrigation_scheduler_if #(.ZONES(4), .TIMER_WIDTH(8)) bus ();
  multi_zone_irrigation_scheduler #(
    .ZONES(4), .TIMER_WIDTH(8), .TICK_DIV(4), .SPRINKLER_TIME(3), .DRIPPER_TIME(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic lvl(input logic [2:0] hml);
    {bus.high_water_level, bus.mid_water_level, bus.low_water_level} = hml;
  endtask
  task automatic run_state(input string tag, input logic [3:0] valve, input int rem);
    check({tag, "_valve"}, bus.zone_valve, valve);
    check({tag, "_rem"}, bus.remaining_seconds, rem);
  endtask
  initial begin
    lvl(3'b111);
    bus.air_humidity = 1'b0;
    bus.low_temperature = 1'b0;
    bus.earth_humidity = 4'hF;
    bus.abort = 1'b0;
    cyc(2);
    run_state("rst", 4'h0, 0);
    check("rst_zone", bus.active_zone, 0);
    check("rst_spr", bus.splinker_bomb, 0);
    check("rst_drip", bus.dripper_valvule, 0);
    check("rst_supply", bus.water_supply_valvule, 0);
    check("rst_alarm", bus.alarm, 0);
    check("rst_conf", bus.conflicting_values, 0);
    reset = 1'b0;
    cyc(2);
    run_state("idle", 4'h0, 0);
    bus.earth_humidity = 4'h0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      run_state("rr_start", 4'b0001 << (k % 4), 3);
      check("rr_zone", bus.active_zone, k % 4);
      check("rr_spr", bus.splinker_bomb, 1);
      check("rr_drip", bus.dripper_valvule, 0);
      cyc(4);
      run_state("rr_t4", 4'b0001 << (k % 4), 2);
      cyc(4);
      run_state("rr_t8", 4'b0001 << (k % 4), 1);
      cyc(3);
      run_state("rr_t11", 4'b0001 << (k % 4), 1);
      cyc(1);
      run_state("rr_end", 4'h0, 0);
    end
    bus.earth_humidity = 4'hF;
    cyc(1);
    bus.air_humidity = 1'b1;
    bus.earth_humidity = 4'b1101;
    cyc(1);
    run_state("ml_start", 4'b0010, 5);
    check("ml_drip0", bus.dripper_valvule, 1);
    check("ml_spr0", bus.splinker_bomb, 0);
    bus.air_humidity = 1'b0;
    cyc(10);
    run_state("ml_t10", 4'b0010, 3);
    check("ml_spr10", bus.splinker_bomb, 0);
    check("ml_drip10", bus.dripper_valvule, 1);
    cyc(9);
    run_state("ml_t19", 4'b0010, 1);
    check("ml_drip19", bus.dripper_valvule, 1);
    cyc(1);
    run_state("ml_end", 4'h0, 0);
    check("ml_drip20", bus.dripper_valvule, 0);
    bus.earth_humidity = 4'hF;
    cyc(1);
    bus.earth_humidity = 4'b1011;
    cyc(1);
    run_state("lw_start", 4'b0100, 3);
    check("lw_zone", bus.active_zone, 2);
    cyc(4);
    run_state("lw_t4", 4'b0100, 2);
    lvl(3'b000);
    cyc(1);
    run_state("lw_hold1", 4'h0, 2);
    check("lw_supply", bus.water_supply_valvule, 1);
    check("lw_alarm", bus.alarm, 1);
    check("lw_spr_off", bus.splinker_bomb, 0);
    cyc(6);
    run_state("lw_hold7", 4'h0, 2);
    lvl(3'b111);
    cyc(1);
    run_state("lw_resume", 4'b0100, 2);
    check("lw_spr_on", bus.splinker_bomb, 1);
    check("lw_supply_off", bus.water_supply_valvule, 0);
    check("lw_alarm_off", bus.alarm, 0);
    cyc(4);
    run_state("lw_t16", 4'b0100, 1);
    cyc(3);
    run_state("lw_t19", 4'b0100, 1);
    cyc(1);
    run_state("lw_end", 4'h0, 0);
    bus.earth_humidity = 4'hF;
    cyc(1);
    bus.earth_humidity = 4'b0111;
    cyc(1);
    run_state("cf_start", 4'b1000, 3);
    cyc(2);
    lvl(3'b101);
    cyc(1);
    run_state("cf_err", 4'h0, 0);
    check("cf_conf", bus.conflicting_values, 1);
    check("cf_alarm", bus.alarm, 1);
    check("cf_supply", bus.water_supply_valvule, 0);
    check("cf_spr", bus.splinker_bomb, 0);
    cyc(1);
    run_state("cf_err2", 4'h0, 0);
    lvl(3'b111);
    cyc(1);
    run_state("cf_idle", 4'h0, 0);
    check("cf_conf_clr", bus.conflicting_values, 0);
    check("cf_alarm_clr", bus.alarm, 0);
    cyc(1);
    run_state("cf_restart", 4'b1000, 3);
    check("cf_zone", bus.active_zone, 3);
    bus.abort = 1'b1;
    bus.earth_humidity = 4'hF;
    cyc(1);
    bus.abort = 1'b0;
    run_state("cf_stop", 4'h0, 0);
    cyc(1);
    bus.earth_humidity = 4'b0001;
    cyc(1);
    run_state("ab_start", 4'b0010, 3);
    cyc(2);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    run_state("ab_idle", 4'h0, 0);
    cyc(1);
    run_state("ab_next", 4'b0100, 3);
    check("ab_zone", bus.active_zone, 2);
    cyc(2);
    bus.earth_humidity = 4'b0101;
    cyc(1);
    run_state("wet_idle", 4'h0, 0);
    cyc(1);
    run_state("wet_next", 4'b1000, 3);
    check("wet_zone", bus.active_zone, 3);
    lvl(3'b001);
    cyc(1);
    check("hy_100_supply", bus.water_supply_valvule, 1);
    check("hy_100_alarm", bus.alarm, 1);
    check("hy_100_valve", bus.zone_valve, 4'b1000);
    lvl(3'b011);
    cyc(1);
    check("hy_110_supply", bus.water_supply_valvule, 1);
    check("hy_110_alarm", bus.alarm, 0);
    lvl(3'b111);
    cyc(1);
    check("hy_111_supply", bus.water_supply_valvule, 0);
    check("hy_run", bus.zone_valve, 4'b1000);
    reset = 1'b1;
    cyc(1);
    run_state("mr_rst", 4'h0, 0);
    check("mr_zone", bus.active_zone, 0);
    check("mr_spr", bus.splinker_bomb, 0);
    check("mr_supply", bus.water_supply_valvule, 0);
    reset = 1'b0;
    bus.earth_humidity = 4'h0;
    cyc(1);
    run_state("mr_first", 4'b0001, 3);
    check("mr_first_zone", bus.active_zone, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_zone_irrigation_scheduler.md
# multi_zone_irrigation_scheduler

Parametrised successor to the single-zone irrigation core. Serves ZONES soil-humidity zones from one reservoir with a round-robin scheduler, one zone irrigating at a time. Each zone gets a per-run countdown in seconds, with sprinkler or dripper mode latched at zone start. The block also provides a hysteretic supply-valve controller, water-sensor conflict detection, and a low-water pause. It sits between the sensor inputs and the display and actuator drivers, replacing the single-zone controller, selector and timer chain.

## Interface
- ZONES, 4: number of irrigation zones (2..16).
- TIMER_WIDTH, 8: width of the seconds countdown.
- TICK_DIV, 50_000_000: clock cycles per one-second tick (>=2).
- SPRINKLER_TIME, 60: run length in ticks for sprinkler mode (1..2^TIMER_WIDTH-1).
- DRIPPER_TIME, 180: run length in ticks for dripper mode (same range).
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- low_water_level / mid_water_level / high_water_level  in  1 each  reservoir at or above that level.
- air_humidity  in  1  1 = humid air.
- low_temperature  in  1  1 = cold.
- earth_humidity  in  ZONES  bit i = 1: zone i soil wet (no request).
- abort  in  1  single-cycle pulse that ends the current zone run.
- zone_valve  out  ZONES  one-hot (or zero) open valve.
- active_zone  out  clog2(ZONES)  index of the zone being served or held.
- splinker_bomb  out  1  sprinkler pump on.
- dripper_valvule  out  1  dripper valve on.
- remaining_seconds  out  TIMER_WIDTH  countdown value.
- water_supply_valvule  out  1  reservoir fill valve.
- alarm  out  1  conflict or water below mid.
- conflicting_values  out  1  registered sensor conflict flag.

## Operation
- Inputs are synchronous to clock (debounced upstream); no internal synchronisers.
- Conflict: conflict_now = (mid & ~low) | (high & ~mid). It is registered into conflicting_values every cycle.
- Mode at zone start: sprinkler iff mid_water_level=1, air_humidity=0 and low_temperature=0; otherwise dripper. Mode is held for the whole run; later mode-input changes are ignored until the next start.
- Request: req[i] = ~earth_humidity[i].
- Round-robin pointer ptr starts at 0. The candidate is the first requesting zone searching ptr, ptr+1, …, wrapping modulo ZONES.
- FSM states:
  - IDLE: all actuators off, remaining_seconds=0. If conflict_now=1, go to ERROR. If low=1 and any req, latch zone and mode, load remaining_seconds with the mode's time, clear the prescaler, and go to RUN.
  - RUN: zone_valve[active_zone]=1 plus the mode actuator. On each tick, remaining_seconds decrements.
  - HOLD: valves off; remaining_seconds, prescaler and mode frozen.
  - ERROR: all actuators off, remaining_seconds=0; ptr unchanged.
- RUN exits, in priority order:
  1. conflict_now=1 → ERROR.
  2. abort=1 → IDLE with ptr=active_zone+1.
  3. earth_humidity[active_zone]=1 → IDLE with ptr=active_zone+1.
  4. low=0 → HOLD.
  5. A tick that takes remaining_seconds to 0 → IDLE with ptr=active_zone+1.
- HOLD exits, in priority order:
  1. conflict_now=1 → ERROR.
  2. abort=1 → IDLE with ptr advanced.
  3. low=1 → RUN, resuming the same zone, mode and count.
- ERROR exit: when conflict_now=0, go to IDLE.
- ptr wrap: ZONES-1 advances to 0.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. tick=1 when count=TICK_DIV-1, then the count returns to 0. The prescaler is cleared on entering RUN from IDLE.
- Supply valve (hysteresis): set when mid=0, cleared when high=1, otherwise held. Forced 0 while conflict_now=1.
- alarm = conflicting_values | ~mid_water_level (mid registered).

## Timing
- Reset values: state=IDLE, ptr=0, active_zone=0, zone_valve=0, splinker_bomb=0, dripper_valvule=0, remaining_seconds=0, water_supply_valvule=0, conflicting_values=0, alarm=0, prescaler=0.
- All outputs are registered.
- The start decision is made at edge k; zone_valve, mode output and remaining_seconds are valid after edge k.
- A run lasts exactly TIME×TICK_DIV cycles of RUN, excluding HOLD time. The valve drops on the edge where remaining_seconds reaches 0.
- The earliest next zone start is one cycle after a run ends, because IDLE occupies one cycle.
- abort, conflict and earth-wet take effect at the edge that samples them; actuators are off in the following cycle.
- Simultaneous events follow the exit priority order above. When tick and abort coincide, the result is abort (ptr advances; same outcome).
- Reset mid-run: the next cycle shows reset values and ptr=0.

## Test plan
All scenarios use ZONES=4, TICK_DIV=4, SPRINKLER_TIME=3, DRIPPER_TIME=5.

- Round-robin: all zones dry, levels 111, air_humidity=0, low_temperature=0 → zones served 0,1,2,3,0. Each run is sprinkler, 12 cycles, remaining_seconds 3→2→1→0, with a 1-cycle gap between runs.
- Mode latch: start with air_humidity=1, then drop it mid-run → dripper for the full 20 cycles, splinker_bomb stays 0.
- Low-water pause: drop low at remaining_seconds=2 for 7 cycles, then restore → valves off for those 7 cycles, count frozen at 2, same zone resumes, 8 further cycles to finish.
- Conflict: levels high=1, mid=0 during RUN → next cycle all valves 0, conflicting_values=1, alarm=1, water_supply_valvule=0. After clearing, IDLE and then the same zone restarts with a full count.
- Abort and wet: abort on zone 1 → zone 2 starts 2 cycles later. Separately, set earth_humidity[2]=1 mid-run → zone 2 stops and zone 3 starts.
- Supply hysteresis and reset: levels 100 → valve 1; levels 110 → valve stays 1; levels 111 → valve 0. Reset during RUN → all outputs 0 next cycle, then zone 0 is served first.
